// File: rtl/piso_stream_if.sv
// Handshake bundle for piso_stream: parallel word in, serial bit stream out.
interface piso_stream_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in;
  logic             in_valid;
  logic             in_ready;
  logic             shift_en;
  logic             out;
  logic             out_valid;
  logic             last;
  logic             busy;

  modport master (
    output in, in_valid, shift_en,
    input  in_ready, out, out_valid, last, busy
  );

  modport slave (
    input  in, in_valid, shift_en,
    output in_ready, out, out_valid, last, busy
  );
endinterface

// File: rtl/piso_stream.sv
// Parallel-in serial-out shifter: a captured word is emitted one bit per
// shift_en cycle, MSB or LSB first, with zero-gap reload on the last bit.
module piso_stream #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  piso_stream_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] shadow_r, shadow_s;
  logic [CW-1:0]    cnt_r, cnt_s, cnt_inc_s;
  logic             out_r, out_s;
  logic             out_valid_r, out_valid_s;
  logic             last_r, last_s;
  logic             in_ready_s;
  logic             accept_s;

  // Selects the bit that goes on the wire for a given position in the word.
  function automatic logic pick_bit(input logic [WIDTH-1:0] word, input logic [CW-1:0] idx);
    logic [CW-1:0] pos;
    if (LSB_FIRST) begin
      pos = idx;
    end else begin
      pos = LAST_CNT - idx;
    end
    return word[pos];
  endfunction

  assign cnt_inc_s  = cnt_r + CNT_ONE;
  assign in_ready_s = rst & ((state_r == IDLE) | (last_r & bus.shift_en));
  assign accept_s   = bus.in_valid & in_ready_s;

  // Next-state and next-output logic; defaults hold every register.
  always_comb begin
    state_s     = state_r;
    shadow_s    = shadow_r;
    cnt_s       = cnt_r;
    out_s       = out_r;
    out_valid_s = out_valid_r;
    last_s      = last_r;
    if (accept_s) begin
      // The first bit leaves on the accept edge itself, so no load bubble.
      state_s     = SHIFT;
      shadow_s    = bus.in;
      cnt_s       = CNT_ZERO;
      out_s       = pick_bit(bus.in, CNT_ZERO);
      out_valid_s = 1'b1;
      last_s      = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          out_s       = 1'b0;
          out_valid_s = 1'b0;
          last_s      = 1'b0;
        end
        SHIFT: begin
          if (bus.shift_en) begin
            if (last_r) begin
              state_s     = IDLE;
              out_s       = 1'b0;
              out_valid_s = 1'b0;
              last_s      = 1'b0;
            end else begin
              cnt_s  = cnt_inc_s;
              out_s  = pick_bit(shadow_r, cnt_inc_s);
              last_s = (cnt_inc_s == LAST_CNT);
            end
          end else begin
            state_s = SHIFT;
          end
        end
        default: begin
          state_s     = IDLE;
          out_s       = 1'b0;
          out_valid_s = 1'b0;
          last_s      = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      shadow_r    <= {WIDTH{1'b0}};
      cnt_r       <= CNT_ZERO;
      out_r       <= 1'b0;
      out_valid_r <= 1'b0;
      last_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      shadow_r    <= shadow_s;
      cnt_r       <= cnt_s;
      out_r       <= out_s;
      out_valid_r <= out_valid_s;
      last_r      <= last_s;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out       = out_r;
  assign bus.out_valid = out_valid_r;
  assign bus.last      = last_r;
  assign bus.busy      = out_valid_r;

endmodule

// File: doc/piso_stream.md
PISO_STREAM -- requirements
Module: piso_stream

Interface
REQ-001 Parameter WIDTH, default 8, parallel word width in bits; legal values are 2 to 64.
REQ-002 Parameter LSB_FIRST, default 0; 0 shifts MSB first, 1 shifts LSB first.
REQ-003 clk  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-004 rst  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-005 in  input  WIDTH  parallel word; it is sampled only on an accept edge.
REQ-006 in_valid  input  1  producer has a word on in.
REQ-007 in_ready  output  1  block can take a word this cycle; combinational.
REQ-008 shift_en  input  1  consumer pacing; 1 advances the serial stream, 0 holds it.
REQ-009 out  output  1  serial data bit; registered.
REQ-010 out_valid  output  1  out carries a valid bit; registered.
REQ-011 last  output  1  out carries the final bit of the current word; registered.
REQ-012 busy  output  1  a word is being serialised; equals out_valid.

Function
REQ-013 The FSM SHALL have two states: IDLE and SHIFT.
REQ-014 The block SHALL hold a WIDTH-bit shadow register and a ceil(log2(WIDTH))-bit bit counter cnt.
REQ-015 An accept SHALL occur on an edge where in_valid=1, in_ready=1 and rst=1.
REQ-016 When rst=0, in_ready SHALL be 0.
REQ-017 When rst=1, in_ready SHALL be 1 in IDLE, or in SHIFT when last=1 and shift_en=1.
REQ-018 On an accept, the block SHALL capture in into the shadow register, set cnt=0 and enter SHIFT.
REQ-019 On the same accept edge, out SHALL become in[WIDTH-1] (LSB_FIRST=0) or in[0] (LSB_FIRST=1), and out_valid SHALL become 1.
REQ-020 Latency from the accept edge to the first valid bit SHALL be 0 cycles: the first bit is on out right after the accept edge.
REQ-021 In SHIFT, on an edge with shift_en=1 and last=0, cnt SHALL increment and out SHALL present the next bit in the selected order.
REQ-022 In SHIFT, on an edge with shift_en=0, out, out_valid, last, cnt and the shadow register SHALL hold.
REQ-023 last SHALL be 1 exactly when out_valid=1 and cnt=WIDTH-1.
REQ-024 On an edge with last=1, shift_en=1 and no accept, the block SHALL go to IDLE with out=0, out_valid=0 and last=0.
REQ-025 On an edge with last=1, shift_en=1 and an accept, the block SHALL load the new word per REQ-018/019 with no idle gap between words.
REQ-026 In SHIFT with last=0, in_valid SHALL be ignored and in SHALL NOT be sampled.
REQ-027 In IDLE, shift_en SHALL have no effect.
REQ-028 In IDLE with in_valid=0, out, out_valid and last SHALL stay 0.
REQ-029 Each accepted word SHALL produce exactly WIDTH bits with out_valid=1 on edges where shift_en=1, regardless of stall pattern.

Reset
REQ-030 On an edge with rst=0, the block SHALL go to IDLE with out=0, out_valid=0, last=0, busy=0, cnt=0 and the shadow register at 0.
REQ-031 Reset SHALL override every other input, including a mid-word transfer; the partial word SHALL be discarded and SHALL NOT resume.
REQ-032 On the first edge with rst=1, an accept SHALL be possible.

Verification (WIDTH=4)
REQ-033 LSB_FIRST=0, shift_en=1, accept 4'b1011 -> out = 1,0,1,1 on 4 consecutive cycles, last=1 on the 4th only, then out_valid=0.
REQ-034 LSB_FIRST=1, accept 4'b1011 -> out = 1,1,0,1; then accept 4'b1010 with no gap -> out = 0,1,0,1.
REQ-035 Back-to-back: in_valid held 1 with words 4'b0101 and 4'b1010 -> 8 contiguous valid bits, in_ready=1 only during the cycles where last=1.
REQ-036 Stall: accept 4'b1011, drop shift_en for 3 cycles after bit 2 -> out holds 0 for those 3 cycles, then continues 1,1; exactly 4 bits are emitted.
REQ-037 Reset mid-word: rst=0 after bit 2 of 4'b1011 -> next edge gives out=0, out_valid=0, in_ready=0 while rst=0; after release, accept 4'b0110 -> out = 0,1,1,0.
REQ-038 Ignored input: change in and pulse in_valid during bits 1-3 -> the serial stream is unchanged.
